dff_debouncer: RTL and testbench
================================

Name: dff_debouncer

Overview:
- Downstream consumer of the single-bit D flip-flop stage.
- Takes the flop's registered output `q` as `din` and debounces it: a level change is accepted only after `STABLE_CYCLES` consecutive agreeing samples.
- Emits the accepted level, one-cycle rise/fall strobes and a running count of accepted edges.
- Used as the clean-input front end for switch and handshake lines, placed after the capture flop.

Parameters:
- STABLE_CYCLES, 4, consecutive differing samples needed to commit a change; legal range 1..255.
- CNT_W, 8, width of the accepted-edge counter.

Ports:
- clk  input  1  rising-edge clock, sole clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  sample from the upstream flop's `q`; already synchronous to `clk`.
- q_stable  output  1  debounced level.
- rise  output  1  one-cycle strobe, q_stable committed 0->1.
- fall  output  1  one-cycle strobe, q_stable committed 1->0.
- busy  output  1  high while a candidate change is being qualified.
- edge_count  output  CNT_W  number of committed edges, modulo 2^CNT_W.

Behaviour:
- Reset and interface:
  - Reset is asynchronous and active-low; it applies immediately on `rst_n` low, independent of `clk`.
  - While in reset: q_stable=0, rise=0, fall=0, busy=0, edge_count=0, state=IDLE_LO, qualify counter=0.
  - All outputs are registered; nothing is combinational from `din` to any output.
- States: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO.
- Qualify counter: internal, width = clog2(STABLE_CYCLES+1).
- Each rising clk edge:
  - IDLE_LO:
    - din=0: stay.
    - din=1 and STABLE_CYCLES=1: commit rise now, go IDLE_HI.
    - din=1 otherwise: counter=1, go CHK_HI.
  - CHK_HI:
    - din=0: abort. Counter=0, go IDLE_LO, no strobe, edge_count unchanged.
    - din=1 and counter==STABLE_CYCLES-1: commit. q_stable=1, rise=1 for one cycle, edge_count+1, counter=0, go IDLE_HI.
    - din=1 otherwise: counter+1.
  - IDLE_HI / CHK_LO: mirror of the above with din inverted; commit drives q_stable=0 and fall=1.
- Latency: a din change first sampled at edge k is committed at edge k+STABLE_CYCLES-1. q_stable and the strobe are visible after that edge.
- rise and fall are never high together. Each deasserts on the following edge unless a new commit occurs; back-to-back commits need STABLE_CYCLES=1.
- busy = (state==CHK_HI || state==CHK_LO), registered with the state.
- edge_count wraps from 2^CNT_W-1 to 0 silently. There is no saturation.
- Reset asserted mid-qualification discards the candidate with no strobe. After release, din held high re-qualifies from zero.
- din toggling every cycle with STABLE_CYCLES>=2 never commits: busy alternates and q_stable holds.

Optional Feature:
- Macro: DFF_DEBOUNCER_CLEAR_EN.
- Defined: adds input port `clr` (1 bit, synchronous, active-high).
  - clr=1 at an edge sets edge_count=0.
  - If a commit happens on the same edge, clr wins: edge_count=0, but rise/fall and q_stable still update normally.
  - clr does not affect the state machine.
- Undefined: no `clr` port; edge_count is cleared only by reset.

Test Plan:
1. STABLE_CYCLES=4. Hold din=1 through reset, release rst_n. -> q_stable=0 until the 4th post-reset edge. Then q_stable=1, rise high exactly 1 cycle, edge_count=1, busy high for 3 cycles.
2. From IDLE_LO, din=1 for 3 edges then 0. -> no rise, q_stable=0, busy falls on the abort edge, edge_count unchanged.
3. From stable high, din=0 for 4 edges. -> fall strobe 1 cycle, q_stable=0, rise stays 0, edge_count increments by 1.
4. CNT_W=2, STABLE_CYCLES=1. Toggle din every cycle for 4 cycles. -> rise/fall alternate each cycle; edge_count goes 1,2,3,0.
5. Assert rst_n=0 asynchronously (mid-cycle) after 2 high samples in CHK_HI. -> all outputs 0 immediately without a clk edge; no rise after release unless din stays high 4 more edges.
6. With DFF_DEBOUNCER_CLEAR_EN, edge_count=5, assert clr on the commit edge of a rise. -> edge_count=0, rise=1, q_stable=1.

Source files
------------

// File: rtl/dff_debouncer.sv
// Debounces a synchronous single-bit sample. It outputs the accepted level, rise/fall strobes and an edge count.
// Optional macro DFF_DEBOUNCER_CLEAR_EN adds a synchronous clr input that zeroes edge_count.
//
// state   | meaning
// IDLE_LO | accepted level 0, din agrees
// CHK_HI  | din high, qualifying a 0->1 change
// IDLE_HI | accepted level 1, din agrees
// CHK_LO  | din low, qualifying a 1->0 change
module dff_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
`ifdef DFF_DEBOUNCER_CLEAR_EN
    input  logic             clr,
`endif
    output logic             q_stable,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [CNT_W-1:0] edge_count
);

    localparam int QW = $clog2(STABLE_CYCLES + 1);
    localparam logic [QW-1:0] LAST = QW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} state_t;

    state_t          state, state_n;
    logic [QW-1:0]   qcnt, qcnt_n;
    logic            commit_rise, commit_fall;
    logic            clr_i;

`ifdef DFF_DEBOUNCER_CLEAR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        qcnt_n      = qcnt;
        commit_rise = 1'b0;
        commit_fall = 1'b0;
        case (state)
            IDLE_LO: begin
                if (din) begin
                    if (STABLE_CYCLES == 1) begin
                        commit_rise = 1'b1;
                        state_n     = IDLE_HI;
                    end else begin
                        qcnt_n  = QW'(1);
                        state_n = CHK_HI;
                    end
                end
            end
            CHK_HI: begin
                if (!din) begin
                    qcnt_n  = '0;
                    state_n = IDLE_LO;
                end else if (qcnt == LAST) begin
                    commit_rise = 1'b1;
                    qcnt_n      = '0;
                    state_n     = IDLE_HI;
                end else begin
                    qcnt_n = qcnt + QW'(1);
                end
            end
            IDLE_HI: begin
                if (!din) begin
                    if (STABLE_CYCLES == 1) begin
                        commit_fall = 1'b1;
                        state_n     = IDLE_LO;
                    end else begin
                        qcnt_n  = QW'(1);
                        state_n = CHK_LO;
                    end
                end
            end
            CHK_LO: begin
                if (din) begin
                    qcnt_n  = '0;
                    state_n = IDLE_HI;
                end else if (qcnt == LAST) begin
                    commit_fall = 1'b1;
                    qcnt_n      = '0;
                    state_n     = IDLE_LO;
                end else begin
                    qcnt_n = qcnt + QW'(1);
                end
            end
            default: begin
                state_n = IDLE_LO;
                qcnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE_LO;
            qcnt       <= '0;
            q_stable   <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            busy       <= 1'b0;
            edge_count <= '0;
        end else begin
            state <= state_n;
            qcnt  <= qcnt_n;
            rise  <= commit_rise;
            fall  <= commit_fall;
            busy  <= (state_n == CHK_HI) || (state_n == CHK_LO);
            if (commit_rise)
                q_stable <= 1'b1;
            else if (commit_fall)
                q_stable <= 1'b0;
            // clear takes priority over a same-edge commit
            if (clr_i)
                edge_count <= '0;
            else if (commit_rise || commit_fall)
                edge_count <= edge_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dff_debouncer.sv
// Scoreboard bench for dff_debouncer: one instance with STABLE_CYCLES=4/CNT_W=8, one with STABLE_CYCLES=1/CNT_W=2.
// The test_clear scenario runs only when DFF_DEBOUNCER_CLEAR_EN is defined.
module tb_dff_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din0, din1;
    logic       clr0, clr1;
    logic       q0, r0, f0, b0;
    logic [7:0] c0;
    logic       q1, r1, f1, b1;
    logic [1:0] c1;

    int errors = 0;
    int checks = 0;

    logic [11:0] sb0[$];
    logic [11:0] sb1[$];

    bit m_q[2];
    int m_run[2];
    int m_cnt[2];

    always #5 clk = ~clk;

    dff_debouncer #(.STABLE_CYCLES(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din0),
`ifdef DFF_DEBOUNCER_CLEAR_EN
        .clr(clr0),
`endif
        .q_stable(q0), .rise(r0), .fall(f0), .busy(b0), .edge_count(c0)
    );

    dff_debouncer #(.STABLE_CYCLES(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1),
`ifdef DFF_DEBOUNCER_CLEAR_EN
        .clr(clr1),
`endif
        .q_stable(q1), .rise(r1), .fall(f1), .busy(b1), .edge_count(c1)
    );

    function automatic logic [11:0] got(input int i);
        if (i == 0) return {q0, r0, f0, b0, c0};
        return {q1, r1, f1, b1, 6'b0, c1};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 1'b0;
            m_run[i] = 0;
            m_cnt[i] = 0;
        end
    endfunction

    // Counts consecutive samples that disagree with the accepted level
    function automatic logic [11:0] model_step(input int i, input bit d, input bit c);
        int  sc  = (i == 0) ? 4 : 1;
        int  mod = (i == 0) ? 256 : 4;
        bit  rs = 1'b0;
        bit  fl = 1'b0;
        if (d != m_q[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == sc) begin
            m_q[i] = d;
            rs = d;
            fl = !d;
            m_cnt[i] = (m_cnt[i] + 1) % mod;
            m_run[i] = 0;
        end
`ifdef DFF_DEBOUNCER_CLEAR_EN
        if (c) m_cnt[i] = 0;
`endif
        return {m_q[i], rs, fl, (m_run[i] != 0), m_cnt[i][7:0]};
    endfunction

    task automatic step(input int i, input bit d, input bit c, input string tag);
        logic [11:0] e, g;
        if (i == 0) begin din0 = d; clr0 = c; end
        else din1 = d;
        e = model_step(i, d, c);
        if (i == 0) sb0.push_back(e); else sb1.push_back(e);
        @(posedge clk);
        #1;
        clr0 = 1'b0;
        if (i == 0) e = sb0.pop_front(); else e = sb1.pop_front();
        g = got(i);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s inst%0d: got q/r/f/b/cnt=%h required %h", tag, i, g, e);
        end
    endtask

    task automatic hold(input int i, input bit d, input int n, input string tag);
        for (int k = 0; k < n; k++) step(i, d, 1'b0, tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din0 = 1'b1; din1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        model_reset();
        #2;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got(0) !== 12'h000) begin
            errors++; $display("FAIL reset0: got %h required 000", got(0));
        end
        checks++;
        if (got(1) !== 12'h000) begin
            errors++; $display("FAIL reset1: got %h required 000", got(1));
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rise();
        int nb = 0, nr = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 1'b1, 1'b0, "rise_qual");
            nb += int'(b0);
            nr += int'(r0);
            if (k < 3) begin
                checks++;
                if (q0 !== 1'b0) begin
                    errors++; $display("FAIL rise_early q: got %b required 0 at edge %0d", q0, k + 1);
                end
            end
        end
        step(0, 1'b1, 1'b0, "rise_after");
        nr += int'(r0);
        checks++;
        if (nb != 3) begin errors++; $display("FAIL rise_busy_cycles: got %0d required 3", nb); end
        checks++;
        if (nr != 1) begin errors++; $display("FAIL rise_strobe_cycles: got %0d required 1", nr); end
        checks++;
        if (c0 !== 8'd1) begin errors++; $display("FAIL rise_count: got %0d required 1", c0); end
    endtask

    task automatic test_fall();
        hold(0, 1'b0, 4, "fall_qual");
        checks++;
        if ({q0, r0, f0, c0} !== {3'b001, 8'd2}) begin
            errors++; $display("FAIL fall_commit: got q/r/f=%b%b%b cnt=%0d required 001 cnt=2", q0, r0, f0, c0);
        end
        step(0, 1'b0, 1'b0, "fall_after");
    endtask

    task automatic test_abort();
        hold(0, 1'b1, 3, "abort_qual");
        step(0, 1'b0, 1'b0, "abort_edge");
        checks++;
        if ({q0, r0, b0, c0} !== {3'b000, 8'd2}) begin
            errors++; $display("FAIL abort: got q/r/b=%b%b%b cnt=%0d required 000 cnt=2", q0, r0, b0, c0);
        end
        hold(0, 1'b0, 2, "abort_idle");
    endtask

    task automatic test_toggle_slow();
        for (int k = 0; k < 8; k++) step(0, bit'(k % 2 == 0), 1'b0, "toggle_sc4");
        hold(0, 1'b0, 1, "toggle_sc4_idle");
    endtask

    task automatic test_back_to_back();
        logic [1:0] want [4];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0;
        for (int k = 0; k < 4; k++) begin
            step(1, bit'(k % 2 == 0), 1'b0, "b2b_toggle");
            checks++;
            if ({r1, f1, c1} !== {bit'(k % 2 == 0), bit'(k % 2 == 1), want[k]}) begin
                errors++;
                $display("FAIL b2b_seq: got r/f=%b%b cnt=%0d required cnt=%0d at step %0d", r1, f1, c1, want[k], k);
            end
        end
        din1 = 1'b0;
    endtask

    task automatic test_async_reset();
        hold(0, 1'b1, 2, "areset_qual");
        checks++;
        if (b0 !== 1'b1) begin errors++; $display("FAIL areset_busy_before: got %b required 1", b0); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (got(0) !== 12'h000) begin
            errors++; $display("FAIL areset_immediate: got %h required 000", got(0));
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        hold(0, 1'b1, 3, "areset_requal");
        checks++;
        if (r0 !== 1'b0) begin errors++; $display("FAIL areset_early_rise: got %b required 0", r0); end
        step(0, 1'b1, 1'b0, "areset_commit");
        checks++;
        if ({q0, r0, c0} !== {2'b11, 8'd1}) begin
            errors++; $display("FAIL areset_commit: got q/r=%b%b cnt=%0d required 11 cnt=1", q0, r0, c0);
        end
    endtask

`ifdef DFF_DEBOUNCER_CLEAR_EN
    task automatic test_clear();
        step(0, 1'b1, 1'b1, "clr_only");
        for (int k = 0; k < 5; k++) hold(0, bit'(k % 2 == 1), 4, "clr_build");
        checks++;
        if (c0 !== 8'd5) begin errors++; $display("FAIL clr_pre_count: got %0d required 5", c0); end
        hold(0, 1'b1, 3, "clr_qual");
        step(0, 1'b1, 1'b1, "clr_commit");
        checks++;
        if ({q0, r0, c0} !== {2'b11, 8'd0}) begin
            errors++; $display("FAIL clr_commit: got q/r=%b%b cnt=%0d required 11 cnt=0", q0, r0, c0);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_abort();
        test_toggle_slow();
        test_back_to_back();
        test_async_reset();
`ifdef DFF_DEBOUNCER_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
